// File: rtl/ysyx_041514_mem_arb_pkg.sv
// ysyx_041514_mem_arb_pkg
// Shared definitions for the icache/dcache memory arbiter:
//   - bus widths for address, data, byte mask and access size
//   - default starvation limit for the icache
//   - arbiter FSM state encoding
//   - latched downstream request record
//   - fixed attributes of an icache refill (full-width read)
//   - helper that sizes the starvation counter from its limit
package ysyx_041514_mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int SIZE_W = 4;

  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
    logic [SIZE_W-1:0] size;
  } mem_req_t;

  // An icache refill is always a full 8-byte read.
  localparam logic [MASK_W-1:0] IFETCH_MASK = 8'hFF;
  localparam logic [SIZE_W-1:0] IFETCH_SIZE = 4'd8;

  // Counter must be able to hold the value STARVE_LIMIT itself.
  function automatic int cnt_width(input int limit);
    if (limit < 1) begin
      return 1;
    end
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ysyx_041514_mem_arb_pick.sv
// ysyx_041514_arb_pick
// Combinational grant decision between icache and dcache.
// Ports:
//   i_req       in   icache request pending
//   d_req       in   dcache request pending
//   starve_cnt  in   consecutive dcache grants made while icache waited
//   grant_i     out  icache wins this IDLE cycle
//   grant_d     out  dcache wins this IDLE cycle
//   starve_nxt  out  starvation count to load at the IDLE-cycle edge
module ysyx_041514_arb_pick #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_i,
  output logic             grant_d,
  output logic [CNT_W-1:0] starve_nxt
);

  logic starve_hit;

  // dcache normally wins; a starved icache takes one grant to break the run.
  assign starve_hit = i_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_i    = i_req && (!d_req || starve_hit);
  assign grant_d    = d_req && !grant_i;

  // Count only dcache grants that overtook a waiting icache; anything else
  // (icache grant, icache not waiting, no grant) restarts the run.
  always_comb begin
    starve_nxt = '0;
    if (grant_d && i_req) begin
      if (starve_cnt == CNT_W'(STARVE_LIMIT)) begin
        starve_nxt = starve_cnt;
      end else begin
        starve_nxt = starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ysyx_041514_mem_arb.sv
// ysyx_041514_mem_arb
// Arbitrates icache refills and dcache accesses onto a single request
// channel towards the AXI bridge. One transaction at a time; the winner's
// request is latched at grant so the downstream fields stay stable.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   i_req_valid_i, i_addr_i     icache read request
//   i_ready_o, i_rdata_o        icache done pulse / read data
//   d_req_valid_i, d_addr_i, d_write_i, d_wdata_i, d_mask_i, d_size_i
//                               dcache request
//   d_ready_o, d_rdata_o        dcache done pulse / read data
//   m_valid_o, m_addr_o, m_write_o, m_wdata_o, m_mask_o, m_size_o
//                               request to the bridge
//   m_ready_i, m_rdata_i        bridge done pulse / read data
//   m_owner_o                   last granted master (0 icache, 1 dcache)
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | no transaction; grant to a requester at the next edge
// ST_BUSY_I | icache refill presented to the bridge, waiting m_ready_i
// ST_BUSY_D | dcache access presented to the bridge, waiting m_ready_i
module ysyx_041514_mem_arb
  import ysyx_041514_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req_valid_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ready_o,
  output logic [DATA_W-1:0] i_rdata_o,

  input  logic              d_req_valid_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_write_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [MASK_W-1:0] d_mask_i,
  input  logic [SIZE_W-1:0] d_size_i,
  output logic              d_ready_o,
  output logic [DATA_W-1:0] d_rdata_o,

  output logic              m_valid_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic              m_write_o,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic [MASK_W-1:0] m_mask_o,
  output logic [SIZE_W-1:0] m_size_o,
  input  logic              m_ready_i,
  input  logic [DATA_W-1:0] m_rdata_i,

  output logic              m_owner_o
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);

  arb_state_e       state;
  mem_req_t         lat_q;
  mem_req_t         i_pkt;
  mem_req_t         d_pkt;
  logic             valid_q;
  logic             owner_q;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             grant_i;
  logic             grant_d;

  ysyx_041514_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .i_req      (i_req_valid_i),
    .d_req      (d_req_valid_i),
    .starve_cnt (starve_cnt),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .starve_nxt (starve_nxt)
  );

  always_comb begin
    i_pkt       = '0;
    i_pkt.addr  = i_addr_i;
    i_pkt.write = 1'b0;
    i_pkt.mask  = IFETCH_MASK;
    i_pkt.size  = IFETCH_SIZE;

    d_pkt       = '0;
    d_pkt.addr  = d_addr_i;
    d_pkt.write = d_write_i;
    d_pkt.wdata = d_wdata_i;
    d_pkt.mask  = d_mask_i;
    d_pkt.size  = d_size_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      lat_q      <= '0;
      valid_q    <= 1'b0;
      owner_q    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          starve_cnt <= starve_nxt;
          if (grant_i) begin
            state   <= ST_BUSY_I;
            lat_q   <= i_pkt;
            valid_q <= 1'b1;
            owner_q <= 1'b0;
          end else if (grant_d) begin
            state   <= ST_BUSY_D;
            lat_q   <= d_pkt;
            valid_q <= 1'b1;
            owner_q <= 1'b1;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // Completion always passes through IDLE, so back-to-back grants
          // are separated by one idle cycle.
          if (m_ready_i) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid_o = valid_q;
  assign m_addr_o  = lat_q.addr;
  assign m_write_o = lat_q.write;
  assign m_wdata_o = lat_q.wdata;
  assign m_mask_o  = lat_q.mask;
  assign m_size_o  = lat_q.size;
  assign m_owner_o = owner_q;

  // A bridge completion coinciding with reset is dropped along with the
  // transaction rather than reported to the master.
  assign i_ready_o = rst && (state == ST_BUSY_I) && m_ready_i;
  assign d_ready_o = rst && (state == ST_BUSY_D) && m_ready_i;
  assign i_rdata_o = i_ready_o ? m_rdata_i : '0;
  assign d_rdata_o = d_ready_o ? m_rdata_i : '0;

endmodule

// File: tb/tb_ysyx_041514_mem_arb.sv
module tb_ysyx_041514_mem_arb;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid_i;
  logic [31:0] i_addr_i;
  logic        i_ready_o;
  logic [63:0] i_rdata_o;
  logic        d_req_valid_i;
  logic [31:0] d_addr_i;
  logic        d_write_i;
  logic [63:0] d_wdata_i;
  logic [7:0]  d_mask_i;
  logic [3:0]  d_size_i;
  logic        d_ready_o;
  logic [63:0] d_rdata_o;
  logic        m_valid_o;
  logic [31:0] m_addr_o;
  logic        m_write_o;
  logic [63:0] m_wdata_o;
  logic [7:0]  m_mask_o;
  logic [3:0]  m_size_o;
  logic        m_ready_i;
  logic [63:0] m_rdata_i;
  logic        m_owner_o;

  always #5 clk = ~clk;

  ysyx_041514_mem_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid_i (i_req_valid_i),
    .i_addr_i      (i_addr_i),
    .i_ready_o     (i_ready_o),
    .i_rdata_o     (i_rdata_o),
    .d_req_valid_i (d_req_valid_i),
    .d_addr_i      (d_addr_i),
    .d_write_i     (d_write_i),
    .d_wdata_i     (d_wdata_i),
    .d_mask_i      (d_mask_i),
    .d_size_i      (d_size_i),
    .d_ready_o     (d_ready_o),
    .d_rdata_o     (d_rdata_o),
    .m_valid_o     (m_valid_o),
    .m_addr_o      (m_addr_o),
    .m_write_o     (m_write_o),
    .m_wdata_o     (m_wdata_o),
    .m_mask_o      (m_mask_o),
    .m_size_o      (m_size_o),
    .m_ready_i     (m_ready_i),
    .m_rdata_i     (m_rdata_i),
    .m_owner_o     (m_owner_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one outstanding transaction, who owns it, what was
  // captured at grant, and how many dcache grants overtook a waiting icache.
  bit          model_ok = 0;
  bit          mdl_busy;
  bit          mdl_own;
  int          mdl_starve;
  logic [31:0] l_addr;
  logic        l_write;
  logic [63:0] l_wdata;
  logic [7:0]  l_mask;
  logic [3:0]  l_size;

  bit          exp_i_done, exp_d_done;
  logic        obs_valid, obs_own, obs_iready, obs_dready, obs_write;
  logic [63:0] obs_irdata, obs_drdata, obs_wdata;
  logic [31:0] obs_addr;
  logic [7:0]  obs_mask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    exp_i_done = rst && mdl_busy && !mdl_own && m_ready_i;
    exp_d_done = rst && mdl_busy &&  mdl_own && m_ready_i;
    obs_valid  = m_valid_o;
    obs_own    = m_owner_o;
    obs_iready = i_ready_o;
    obs_dready = d_ready_o;
    obs_irdata = i_rdata_o;
    obs_drdata = d_rdata_o;
    obs_addr   = m_addr_o;
    obs_write  = m_write_o;
    obs_wdata  = m_wdata_o;
    obs_mask   = m_mask_o;
    if (!model_ok) return;
    chk("m_valid", 64'(m_valid_o), 64'(mdl_busy));
    chk("m_owner", 64'(m_owner_o), 64'(mdl_own));
    chk("i_ready", 64'(i_ready_o), 64'(exp_i_done));
    chk("d_ready", 64'(d_ready_o), 64'(exp_d_done));
    chk("i_rdata", i_rdata_o, exp_i_done ? m_rdata_i : 64'd0);
    chk("d_rdata", d_rdata_o, exp_d_done ? m_rdata_i : 64'd0);
    if (mdl_busy) begin
      chk("m_addr",  64'(m_addr_o),  64'(l_addr));
      chk("m_write", 64'(m_write_o), 64'(l_write));
      chk("m_wdata", m_wdata_o,      l_wdata);
      chk("m_mask",  64'(m_mask_o),  64'(l_mask));
      chk("m_size",  64'(m_size_o),  64'(l_size));
    end
  endtask

  task automatic model_update();
    bit pick_i;
    if (!rst) begin
      model_ok   = 1;
      mdl_busy   = 0;
      mdl_own    = 0;
      mdl_starve = 0;
      l_addr = '0; l_write = 0; l_wdata = '0; l_mask = '0; l_size = '0;
    end else if (model_ok) begin
      if (!mdl_busy) begin
        if (i_req_valid_i || d_req_valid_i) begin
          pick_i = i_req_valid_i && (!d_req_valid_i || mdl_starve == LIMIT);
          if (pick_i) begin
            l_addr = i_addr_i; l_write = 0; l_wdata = '0; l_mask = 8'hFF; l_size = 4'd8;
            mdl_own    = 0;
            mdl_starve = 0;
          end else begin
            l_addr = d_addr_i; l_write = d_write_i; l_wdata = d_wdata_i;
            l_mask = d_mask_i; l_size = d_size_i;
            mdl_own    = 1;
            mdl_starve = i_req_valid_i ? ((mdl_starve + 1 > LIMIT) ? LIMIT : mdl_starve + 1) : 0;
          end
          mdl_busy = 1;
        end else begin
          mdl_starve = 0;
        end
      end else if (m_ready_i) begin
        mdl_busy = 0;
      end
    end
  endtask

  // Inputs are set right after a rising edge; outputs are checked mid-cycle.
  task automatic step();
    #4;
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req_valid_i = 0; i_addr_i = '0;
    d_req_valid_i = 0; d_addr_i = '0; d_write_i = 0; d_wdata_i = '0;
    d_mask_i = '0; d_size_i = '0;
    m_ready_i = 0; m_rdata_i = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt, rcnt, dgr, icnt;
    bit seen_i, i_pend, d_pend;
    logic [63:0] got;

    clear_inputs();
    rst = 0;
    @(posedge clk); #1;
    step();
    step();
    chk("reset_valid", 64'(obs_valid), 64'd0);
    chk("reset_owner", 64'(obs_own), 64'd0);
    rst = 1;
    step();

    // dcache read, bridge done on the third busy cycle
    d_req_valid_i = 1; d_addr_i = 32'h8000_0010; d_write_i = 0;
    d_mask_i = 8'hFF; d_size_i = 4'd8;
    step();
    chk("t030_idle_valid", 64'(obs_valid), 64'd0);
    vcnt = 0; rcnt = 0; got = '0;
    for (int c = 0; c < 3; c++) begin
      m_ready_i = (c == 2);
      m_rdata_i = (c == 2) ? 64'h1122_3344_5566_7788 : 64'hDEAD_BEEF_0000_0000;
      step();
      vcnt += int'(obs_valid);
      rcnt += int'(obs_dready);
      if (obs_dready) got = obs_drdata;
      if (c == 0) chk("t030_addr", 64'(obs_addr), 64'h8000_0010);
    end
    d_req_valid_i = 0; m_ready_i = 0;
    step();
    vcnt += int'(obs_valid);
    chk("t030_valid_cycles", 64'(vcnt), 64'd3);
    chk("t030_ready_pulses", 64'(rcnt), 64'd1);
    chk("t030_rdata", got, 64'h1122_3344_5566_7788);

    // simultaneous requests: dcache first, icache after one idle cycle
    i_req_valid_i = 1; i_addr_i = 32'h8000_0100;
    d_req_valid_i = 1; d_addr_i = 32'h8000_0200;
    step();
    m_ready_i = 1; m_rdata_i = 64'h55;
    step();
    chk("t031_first_owner", 64'(obs_own), 64'd1);
    chk("t031_first_dready", 64'(obs_dready), 64'd1);
    d_req_valid_i = 0; m_ready_i = 0;
    step();
    chk("t031_gap_valid", 64'(obs_valid), 64'd0);
    m_ready_i = 1; m_rdata_i = 64'h66;
    step();
    chk("t031_second_owner", 64'(obs_own), 64'd0);
    chk("t031_second_iready", 64'(obs_iready), 64'd1);
    chk("t031_second_irdata", obs_irdata, 64'h66);
    i_req_valid_i = 0; m_ready_i = 0;
    step();

    // starvation: icache waits while dcache keeps requesting
    i_req_valid_i = 1; i_addr_i = 32'h8000_0300;
    d_req_valid_i = 1; d_addr_i = 32'h8000_0400;
    dgr = 0; seen_i = 0;
    for (int c = 0; c < 60 && !seen_i; c++) begin
      m_ready_i = mdl_busy;
      m_rdata_i = 64'(c);
      step();
      if (obs_valid) begin
        if (obs_own) begin
          dgr++;
        end else begin
          seen_i = 1;
          chk("t032_starve_cleared", 64'(dut.starve_cnt), 64'd0);
        end
      end
    end
    chk("t032_icache_granted", 64'(seen_i), 64'd1);
    chk("t032_dcache_grants", 64'(dgr), 64'(LIMIT));
    i_req_valid_i = 0; d_req_valid_i = 0; m_ready_i = 0;
    step();

    // dcache store with inputs zeroed after grant
    d_req_valid_i = 1; d_write_i = 1; d_addr_i = 32'h8000_0004;
    d_wdata_i = 64'hAB; d_mask_i = 8'h10; d_size_i = 4'd1;
    step();
    clear_inputs();
    step();
    chk("t033_addr_hold", 64'(obs_addr), 64'h8000_0004);
    chk("t033_wdata_hold", obs_wdata, 64'hAB);
    chk("t033_mask_hold", 64'(obs_mask), 64'h10);
    chk("t033_write_hold", 64'(obs_write), 64'd1);
    m_ready_i = 1;
    step();
    chk("t033_addr_at_done", 64'(obs_addr), 64'h8000_0004);
    chk("t033_dready_after_drop", 64'(obs_dready), 64'd1);
    m_ready_i = 0;
    step();

    // reset in the middle of an icache refill
    i_req_valid_i = 1; i_addr_i = 32'h8000_1000;
    icnt = 0;
    step();
    step();
    icnt += int'(obs_iready);
    chk("t034_busy_before_rst", 64'(obs_valid), 64'd1);
    rst = 0; i_req_valid_i = 0;
    step();
    icnt += int'(obs_iready);
    rst = 1;
    step();
    icnt += int'(obs_iready);
    chk("t034_valid_after_rst", 64'(obs_valid), 64'd0);
    chk("t034_no_iready", 64'(icnt), 64'd0);

    // bridge done pulse while idle
    m_ready_i = 1; m_rdata_i = 64'hFFFF_0000_FFFF_0000;
    step();
    chk("t035_iready", 64'(obs_iready), 64'd0);
    chk("t035_dready", 64'(obs_dready), 64'd0);
    m_ready_i = 0;
    step();
    chk("t035_still_idle", 64'(obs_valid), 64'd0);

    // randomized traffic against the model
    clear_inputs();
    i_pend = 0; d_pend = 0;
    exp_i_done = 0; exp_d_done = 0;
    for (int c = 0; c < 4000; c++) begin
      if (exp_i_done) i_pend = 0;
      if (exp_d_done) d_pend = 0;
      if (!i_pend && $urandom_range(3) == 0) begin
        i_pend = 1;
        i_addr_i = $urandom & 32'hFFFF_FFF8;
      end
      if (!d_pend && !(mdl_busy && mdl_own) && $urandom_range(2) == 0) begin
        d_pend = 1;
        d_addr_i = $urandom;
        d_write_i = 1'($urandom_range(1));
        d_wdata_i = {$urandom, $urandom};
        d_mask_i = 8'($urandom);
        d_size_i = 4'($urandom_range(8));
      end else if (d_pend && mdl_busy && mdl_own && $urandom_range(3) == 0) begin
        d_addr_i = $urandom;
        d_wdata_i = {$urandom, $urandom};
        d_mask_i = 8'($urandom);
      end
      if (d_pend && mdl_busy && mdl_own && $urandom_range(15) == 0) d_pend = 0;
      i_req_valid_i = i_pend;
      d_req_valid_i = d_pend;
      m_ready_i = mdl_busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      m_rdata_i = {$urandom, $urandom};
      rst = ($urandom_range(199) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
